// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through/no-write-allocate data cache for the Riscv151 memory stage.
// Load hits answer the cycle after acceptance; misses and stores stall until the memory handshakes finish.
module dcache_ctrl #(
  parameter int LINES     = 64,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_write,
  input  logic [31:0]          cpu_req_addr,
  input  logic [31:0]          cpu_req_data,
  input  logic [3:0]           cpu_req_wmask,
  output logic [31:0]          cpu_resp_data,
  output logic                 stall,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_rw,
  output logic [27:0]          mem_req_addr,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [LINE_BITS-1:0] mem_req_data_bits,
  output logic [15:0]          mem_req_data_mask,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, MWAIT, RESP, WRITE} state_t;

  state_t               state;
  logic [27:0]          req_line;
  logic [1:0]           req_off;
  logic                 req_write;
  logic [31:0]          req_data;
  logic [3:0]           req_wmask;
  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0] merged;
  logic [31:0]          resp_word;
  logic                 cmd_done;
  logic                 data_done;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic                 done_now;
  logic                 accept;
  logic                 unused;

  assign unused   = ^cpu_req_addr[1:0];
  assign req_idx  = req_line[IDX_W-1:0];
  assign req_tag  = req_line[27:IDX_W];
  assign hit      = valid_q[req_idx] && (rd_tag == req_tag);
  // Command and data channels may complete in different cycles; the write ends when both have.
  assign done_now = (cmd_done || mem_req_ready) && (data_done || mem_req_data_ready);
  assign accept   = cpu_req_valid && !stall;

  always_comb begin
    stall = 1'b0;
    case (state)
      LOOKUP:      stall = req_write || !hit;
      MREQ, MWAIT: stall = 1'b1;
      WRITE:       stall = !done_now;
      default:     stall = 1'b0;
    endcase
  end

  always_comb begin
    cpu_resp_data = 32'h0;
    if (state == LOOKUP && !req_write && hit)
      cpu_resp_data = rd_line[{req_off, 5'b0} +: 32];
    else if (state == RESP)
      cpu_resp_data = resp_word;
  end

  assign mem_req_valid      = (state == MREQ) || (state == WRITE && !cmd_done);
  assign mem_req_rw         = (state == WRITE);
  assign mem_req_data_valid = (state == WRITE) && !data_done;
  assign mem_req_addr       = req_line;
  assign mem_req_data_bits  = {(LINE_BITS/32){req_data}};
  assign mem_req_data_mask  = {12'b0, req_wmask} << {req_off, 2'b00};

  always_comb begin
    merged = rd_line;
    for (int b = 0; b < 16; b++)
      if (mem_req_data_mask[b]) merged[8*b +: 8] = mem_req_data_bits[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && req_write && hit)
      data_mem[req_idx] <= merged;
    if (state == MWAIT && mem_resp_valid) begin
      data_mem[req_idx] <= mem_resp_data;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_line  <= '0;
      req_off   <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
      req_wmask <= '0;
      valid_q   <= '0;
      rd_tag    <= '0;
      rd_line   <= '0;
      resp_word <= '0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
    end else begin
      if (accept) begin
        req_line  <= cpu_req_addr[31:4];
        req_off   <= cpu_req_addr[3:2];
        req_write <= cpu_req_write;
        req_data  <= cpu_req_data;
        req_wmask <= cpu_req_wmask;
        rd_tag    <= tag_mem[cpu_req_addr[IDX_W+3:4]];
        rd_line   <= data_mem[cpu_req_addr[IDX_W+3:4]];
      end
      case (state)
        IDLE:
          if (accept) state <= LOOKUP;
        LOOKUP:
          if (req_write) begin
            state     <= WRITE;
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
          end else if (hit) begin
            state <= accept ? LOOKUP : IDLE;
          end else begin
            state <= MREQ;
          end
        MREQ:
          if (mem_req_ready) state <= MWAIT;
        MWAIT:
          if (mem_resp_valid) begin
            valid_q[req_idx] <= 1'b1;
            resp_word        <= mem_resp_data[{req_off, 5'b0} +: 32];
            state            <= RESP;
          end
        RESP:
          state <= accept ? LOOKUP : IDLE;
        WRITE: begin
          if (mem_req_ready)      cmd_done  <= 1'b1;
          if (mem_req_data_ready) data_done <= 1'b1;
          if (done_now) state <= accept ? LOOKUP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, misses, stores, conflicts, backpressure and reset mid-refill.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid, cpu_req_write;
  logic [31:0]  cpu_req_addr, cpu_req_data;
  logic [3:0]   cpu_req_wmask;
  logic [31:0]  cpu_resp_data;
  logic         stall;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] D0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] D1 = 128'h77777777_66666666_55555555_44444444;

  dcache_ctrl #(.LINES(64), .LINE_BITS(128)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_wmask(cpu_req_wmask),
    .cpu_resp_data(cpu_resp_data), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mvalid"}, mem_req_valid, 0);
    chk({tag, "_dvalid"}, mem_req_data_valid, 0);
    chk({tag, "_rw"}, mem_req_rw, 0);
    chk({tag, "_resp"}, cpu_resp_data, 0);
    chk({tag, "_addr"}, mem_req_addr, 0);
    chk({tag, "_bits"}, mem_req_data_bits, 0);
    chk({tag, "_mask"}, mem_req_data_mask, 0);
  endtask

  // Issues a request for one cycle; returns 1ns after the next falling edge (first cycle after acceptance).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_data  = d;
    cpu_req_wmask = m;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    #1;
  endtask

  // From a missing LOOKUP cycle: immediate command accept, one-cycle refill, ends in RESP.
  task automatic refill(input string tag, input logic [27:0] line, input logic [127:0] d,
                        input logic [31:0] expw);
    @(negedge clk); #1;
    chk({tag, "_mreq_valid"}, mem_req_valid, 1);
    chk({tag, "_mreq_rw"}, mem_req_rw, 0);
    chk({tag, "_mreq_addr"}, mem_req_addr, line);
    chk({tag, "_mreq_stall"}, stall, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk({tag, "_mwait_valid"}, mem_req_valid, 0);
    chk({tag, "_mwait_stall"}, stall, 1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk({tag, "_resp_stall"}, stall, 0);
    chk({tag, "_resp_data"}, cpu_resp_data, expw);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = 0; cpu_req_data = 0; cpu_req_wmask = 0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    reset = 1'b0;
    @(negedge clk); #1;
    chk_reset_outs("post_rst");

    // Cold miss on 0x1004
    issue(0, 32'h0000_1004, 32'h0, 4'h0);
    chk("miss1_lookup_stall", stall, 1);
    chk("miss1_lookup_mvalid", mem_req_valid, 0);
    refill("miss1", 28'h0000100, D0, 32'h11111111);

    // Hit from RESP, then a back-to-back hit
    cpu_req_valid = 1; cpu_req_write = 0; cpu_req_addr = 32'h0000_1008;
    @(negedge clk);
    cpu_req_addr = 32'h0000_1000;
    #1;
    chk("hit1_stall", stall, 0);
    chk("hit1_mvalid", mem_req_valid, 0);
    chk("hit1_data", cpu_resp_data, 32'h22222222);
    @(negedge clk);
    cpu_req_valid = 0;
    #1;
    chk("hit2_stall", stall, 0);
    chk("hit2_data", cpu_resp_data, 32'h00000000);

    // Store hit with both readies already high in the first WRITE cycle
    @(negedge clk); #1;
    issue(1, 32'h0000_100C, 32'hDEADBEEF, 4'b0011);
    chk("st1_lookup_stall", stall, 1);
    @(negedge clk); #1;
    chk("st1_mvalid", mem_req_valid, 1);
    chk("st1_rw", mem_req_rw, 1);
    chk("st1_dvalid", mem_req_data_valid, 1);
    chk("st1_addr", mem_req_addr, 28'h0000100);
    chk("st1_bits", mem_req_data_bits, {4{32'hDEADBEEF}});
    chk("st1_mask", mem_req_data_mask, 16'h3000);
    chk("st1_stall_wait", stall, 1);
    mem_req_ready = 1; mem_req_data_ready = 1;
    #1;
    chk("st1_stall_done", stall, 0);
    @(negedge clk);
    mem_req_ready = 0; mem_req_data_ready = 0;
    #1;
    chk("st1_idle_mvalid", mem_req_valid, 0);
    chk("st1_idle_dvalid", mem_req_data_valid, 0);
    issue(0, 32'h0000_100C, 32'h0, 4'h0);
    chk("st1_rd_stall", stall, 0);
    chk("st1_rd_data", cpu_resp_data, 32'h3333BEEF);

    // Conflict miss on index 0, then the original line misses again
    @(negedge clk); #1;
    issue(0, 32'h0000_1404, 32'h0, 4'h0);
    chk("conf_lookup_stall", stall, 1);
    refill("conf", 28'h0000140, D1, 32'h55555555);
    issue(0, 32'h0000_1004, 32'h0, 4'h0);
    chk("remiss_lookup_stall", stall, 1);

    // Command backpressure on the refill: ready low for five cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_mreq_valid", mem_req_valid, 1);
      chk("bp_mreq_addr", mem_req_addr, 28'h0000100);
      chk("bp_mreq_rw", mem_req_rw, 0);
      chk("bp_mreq_stall", stall, 1);
    end
    @(negedge clk);
    mem_req_ready = 1;
    #1;
    chk("bp_mreq_valid_acc", mem_req_valid, 1);
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = D0;
    #1;
    chk("bp_mwait_stall", stall, 1);
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    chk("bp_resp_data", cpu_resp_data, 32'h11111111);
    chk("bp_resp_stall", stall, 0);

    // Store with write-data backpressure for three cycles after the command is taken
    issue(1, 32'h0000_1008, 32'h0000AB00, 4'b0010);
    chk("st2_lookup_stall", stall, 1);
    @(negedge clk);
    mem_req_ready = 1;
    #1;
    chk("st2_both_mvalid", mem_req_valid, 1);
    chk("st2_both_dvalid", mem_req_data_valid, 1);
    chk("st2_both_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req_ready = 0;
      #1;
      chk("st2_bp_mvalid", mem_req_valid, 0);
      chk("st2_bp_dvalid", mem_req_data_valid, 1);
      chk("st2_bp_bits", mem_req_data_bits, {4{32'h0000AB00}});
      chk("st2_bp_mask", mem_req_data_mask, 16'h0200);
      chk("st2_bp_rw", mem_req_rw, 1);
      chk("st2_bp_stall", stall, 1);
    end
    @(negedge clk);
    mem_req_data_ready = 1;
    #1;
    chk("st2_done_stall", stall, 0);
    chk("st2_done_dvalid", mem_req_data_valid, 1);
    @(negedge clk);
    mem_req_data_ready = 0;
    #1;
    chk("st2_idle_dvalid", mem_req_data_valid, 0);
    issue(0, 32'h0000_1008, 32'h0, 4'h0);
    chk("st2_rd_stall", stall, 0);
    chk("st2_rd_data", cpu_resp_data, 32'h2222AB22);

    // Reset during MWAIT; a late response must be ignored
    @(negedge clk); #1;
    issue(0, 32'h0000_2004, 32'h0, 4'h0);
    chk("rm_lookup_stall", stall, 1);
    @(negedge clk);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #1;
    chk("rm_mwait_stall", stall, 1);
    reset = 1;
    #1;
    chk_reset_outs("rm_rst");
    @(negedge clk);
    reset = 0;
    mem_resp_valid = 1; mem_resp_data = D1;
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    chk_reset_outs("rm_late");
    issue(0, 32'h0000_1004, 32'h0, 4'h0);
    chk("rm_remiss_stall", stall, 1);
    refill("rm_refill", 28'h0000100, D0, 32'h11111111);

    // Store miss at minimum latency; a load accepted in the completing cycle still hits the untouched line
    issue(1, 32'h0000_3004, 32'hFFFFFFFF, 4'hF);
    chk("st3_lookup_stall", stall, 1);
    mem_req_ready = 1; mem_req_data_ready = 1;
    @(negedge clk); #1;
    chk("st3_stall", stall, 0);
    chk("st3_mask", mem_req_data_mask, 16'h00F0);
    chk("st3_addr", mem_req_addr, 28'h0000300);
    issue(0, 32'h0000_1004, 32'h0, 4'h0);
    mem_req_ready = 0; mem_req_data_ready = 0;
    #1;
    chk("st3_rd_stall", stall, 0);
    chk("st3_rd_data", cpu_resp_data, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
